// File: rtl/key_write_arb.sv
// Round-robin arbiter sharing one key-write port among NREQ setup-style requesters.
// Define ARB_TIMEOUT_EN to add an ack-wait timeout (TIMEOUT cycles) with a sticky err flag.
module key_write_arb #(
   parameter int NREQ    = 4,
   parameter int DW      = 32,
   parameter int TIMEOUT = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NREQ-1:0]    writeReq,
   input  logic [NREQ*DW-1:0] key_in,
   output logic [NREQ-1:0]    writeSucceeded,
   output logic               mem_wr_req,
   output logic [DW-1:0]      mem_key,
   input  logic               mem_wr_ack,
   output logic [2:0]         grant_id,
   output logic               busy,
   output logic               err
);

   typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;

   localparam logic [2:0] LAST_RST = 3'(NREQ - 1);

   state_t        state_q, state_d;
   logic [2:0]    grant_q, grant_d;
   logic [2:0]    last_q, last_d;
   logic [DW-1:0] key_q, key_d;

   logic [2:0]    pick;
   logic          pick_vld;
   logic [DW-1:0] pick_key;
   logic          tmo;
   logic          hold_ok;

   // Search requesters above last first, then wrap around to 0..last.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
      pick     = last_q;
      pick_vld = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         if (!pick_vld && writeReq[i] && (3'(i) > last_q)) begin
            pick_vld = 1'b1;
            pick     = 3'(i);
         end
      end
      for (int i = 0; i < NREQ; i++) begin
         if (!pick_vld && writeReq[i] && (3'(i) <= last_q)) begin
            pick_vld = 1'b1;
            pick     = 3'(i);
         end
      end
   end

   always_comb begin
      pick_key = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (pick == 3'(i)) pick_key = key_in[i*DW +: DW];
      end
   end

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      last_d  = last_q;
      key_d   = key_q;
      case (state_q)
         IDLE: begin
            if (pick_vld) begin
               grant_d = pick;
               key_d   = pick_key;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            // A timed-out requester still moves to the back of the order.
            if (mem_wr_ack || tmo) begin
               last_d  = grant_q;
               state_d = HOLD;
            end
         end
         HOLD:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         grant_q <= LAST_RST;
         last_q  <= LAST_RST;
         key_q   <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so all registers update together.
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
         key_q   <= key_d;
      end
   end

`ifdef ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          to_q, to_d;
   logic          err_q, err_d;

   assign tmo     = (state_q == ISSUE) && !mem_wr_ack && (cnt_q == CW'(TIMEOUT - 1));
   assign cnt_d   = (state_q == ISSUE) ? cnt_q + CW'(1) : '0;
   assign to_d    = tmo;
   assign err_d   = err_q | tmo;
   assign hold_ok = (state_q == HOLD) && !to_q;
   assign err     = err_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
         to_q  <= 1'b0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         to_q  <= to_d;
         err_q <= err_d;
      end
   end
`else
   assign tmo     = 1'b0;
   assign hold_ok = (state_q == HOLD);
   assign err     = 1'b0;
`endif

   always_comb begin
      writeSucceeded = '0;
      for (int i = 0; i < NREQ; i++) begin
         writeSucceeded[i] = hold_ok && (grant_q == 3'(i));
      end
   end

   assign mem_wr_req = (state_q == ISSUE);
   assign mem_key    = (state_q == ISSUE) ? key_q : '0;
   assign busy       = (state_q != IDLE);
   assign grant_id   = grant_q;

endmodule
